rtc_set_core: RTL and testbench
===============================

Name: rtc_set_core

Overview:
Parametrised real-time-clock core. It replaces the fixed divisor-plus-counter pair with one block that holds a prescaler, an HH:MM:SS counter and a set-mode FSM. Debounced increment, decrement and config levels let the user edit hours, minutes and seconds. The block sits between the debouncers and the 8-digit display driver, and exports a blink phase so the driver can flash the field being edited.

Parameters:
CLK_FREQ_HZ, 100_000_000, input clock frequency
TICK_HZ, 1, timekeeping tick rate; the prescaler period is CLK_FREQ_HZ/TICK_HZ cycles (integer, ≥2)
BLINK_DIV, 25_000_000, clock cycles per blink half-period (≥1)
HOURS_MAX, 24, hour modulus; hours count 0..HOURS_MAX-1; legal range 2..32

Ports:
clk_100MHz_i  in  1  system clock
reset_i  in  1  synchronous, active-high reset
increment_i  in  1  debounced level, increment request
decrement_i  in  1  debounced level, decrement request
config_i  in  1  debounced level, advance set mode
seconds_o  out  6  seconds 0..59
minutes_o  out  6  minutes 0..59
hours_o  out  5  hours 0..HOURS_MAX-1
mode_o  out  2  0=RUN, 1=SET_H, 2=SET_M, 3=SET_S
blink_o  out  1  display-enable phase for the edited field
tick_o  out  1  one-cycle pulse when a tick advances the time

Behaviour:
- Reset:
  - One clock, clk_100MHz_i.
  - reset_i is synchronous and active-high.
  - Reset clears the prescaler, seconds/minutes/hours, the edge-detect registers and the blink counter.
  - Reset sets the FSM to RUN. Outputs after reset: time 00:00:00, mode_o=0, blink_o=1, tick_o=0.
- Edge detection:
  - Each of increment_i, decrement_i and config_i is registered once.
  - An event is input high while the registered copy is low, i.e. a rising edge. Holding an input high produces exactly one event.
  - The edge-detect registers are cleared by reset, so an input already high when reset releases produces an event on the first cycle after release.
- Prescaler:
  - Counts 0..P-1, where P = CLK_FREQ_HZ/TICK_HZ, and runs only in RUN.
  - At count P-1 it wraps to 0. On that same cycle the time advances and tick_o is 1.
  - In SET states the prescaler is held at 0.
  - The first tick after returning to RUN therefore fires exactly P cycles later.
- Time advance on tick:
  - seconds +1; from 59 it wraps to 0 and carries into minutes.
  - minutes +1; from 59 it wraps to 0 and carries into hours.
  - hours +1; from HOURS_MAX-1 it wraps to 0.
  - All carries resolve in the same cycle; outputs are registered.
- FSM:
  - A config event steps RUN→SET_H→SET_M→SET_S→RUN.
  - Increment and decrement events are ignored in RUN.
- Editing in SET_x:
  - An increment event adds 1 to field x modulo its range: 59→0, and HOURS_MAX-1→0.
  - A decrement event subtracts 1: 0→59 for minutes/seconds, 0→HOURS_MAX-1 for hours.
  - Editing never carries into other fields.
  - Seconds, minutes and hours are frozen in SET states apart from the edit.
- Simultaneous events:
  - Increment and decrement in the same cycle: both ignored.
  - Config together with increment or decrement: config wins and the field is unchanged.
- Blink:
  - Free-running counter 0..BLINK_DIV-1. At terminal count it wraps and toggles a phase register that resets to 1.
  - blink_o = 1 in RUN, phase in SET states.
  - On entering any SET state, the counter clears and phase is set to 1, so the edited field is visible immediately.
- Latency: the mode and time outputs update 1 cycle after the event cycle; the event cycle is the cycle the raw input is first sampled high.
- Reset mid-edit returns to RUN at 00:00:00.

Test Plan:
- Params CLK_FREQ_HZ=10, TICK_HZ=1, BLINK_DIV=4. Release reset and run 600 cycles → tick_o pulses every 10 cycles; time reads 00:01:00, mode_o=0.
- Preload 00:59:59 (via SET) and return to RUN; wait one tick → 01:00:00. Preload 23:59:59 with HOURS_MAX=24 → 00:00:00. With HOURS_MAX=12, 11:59:59 → 00:00:00.
- Config pulse → mode_o=1. Decrement at hours=0 → hours=HOURS_MAX-1. Increment three times → hours=2. Hold increment high 50 cycles → exactly one increment.
- Sequence config ×4 → mode_o 1,2,3,0. No tick occurs while in SET for 100 cycles. The first tick comes exactly 10 cycles after re-entering RUN.
- Increment and decrement asserted on the same cycle in SET_M → minutes unchanged. Config and increment on the same cycle → mode advances, field unchanged.
- Enter SET_S → blink_o=1 for 4 cycles, then 0 for 4, repeating. Assert reset_i mid-blink → next cycle mode_o=0, blink_o=1, time 00:00:00.

Source files
------------

// File: rtl/rtc_set_core.sv
// Real-time-clock core: tick prescaler, HH:MM:SS counter and set-mode FSM in one block.
// Outputs the time, the field being edited and a blink phase for the display driver.
module rtc_set_core #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 1,
  parameter int BLINK_DIV   = 25_000_000,
  parameter int HOURS_MAX   = 24
) (
  input  logic       clk_100MHz_i,
  input  logic       reset_i,
  input  logic       increment_i,
  input  logic       decrement_i,
  input  logic       config_i,
  output logic [5:0] seconds_o,
  output logic [5:0] minutes_o,
  output logic [4:0] hours_o,
  output logic [1:0] mode_o,
  output logic       blink_o,
  output logic       tick_o
);

  localparam int PRESC = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW    = $clog2(PRESC);
  localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [5:0]    MS_LAST    = 6'd59;
  localparam logic [4:0]    HR_LAST    = 5'(HOURS_MAX - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } mode_e;

  function automatic logic [5:0] inc6(input logic [5:0] v, input logic [5:0] last);
    if (v >= last) begin
      return 6'd0;
    end else begin
      return v + 6'd1;
    end
  endfunction

  function automatic logic [5:0] dec6(input logic [5:0] v, input logic [5:0] last);
    if ((v == 6'd0) || (v > last)) begin
      return last;
    end else begin
      return v - 6'd1;
    end
  endfunction

  function automatic logic [4:0] inc5(input logic [4:0] v, input logic [4:0] last);
    if (v >= last) begin
      return 5'd0;
    end else begin
      return v + 5'd1;
    end
  endfunction

  function automatic logic [4:0] dec5(input logic [4:0] v, input logic [4:0] last);
    if ((v == 5'd0) || (v > last)) begin
      return last;
    end else begin
      return v - 5'd1;
    end
  endfunction

  logic          inc_q, dec_q, cfg_q;
  mode_e         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic [4:0]    hr_q, hr_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          blink_q, blink_d;
  logic          tick_q;

  logic inc_ev_s, dec_ev_s, cfg_ev_s;
  logic edit_inc_s, edit_dec_s;
  logic run_s, tick_s, entering_set_s;

  // Rising-edge events; config overrides edits and opposing edits cancel.
  always_comb begin
    inc_ev_s   = increment_i & ~inc_q;
    dec_ev_s   = decrement_i & ~dec_q;
    cfg_ev_s   = config_i & ~cfg_q;
    edit_inc_s = inc_ev_s & ~dec_ev_s & ~cfg_ev_s;
    edit_dec_s = dec_ev_s & ~inc_ev_s & ~cfg_ev_s;
  end

  // Set-mode sequencing driven by config events.
  always_comb begin
    mode_d = mode_q;
    if (cfg_ev_s) begin
      case (mode_q)
        RUN:     mode_d = SET_H;
        SET_H:   mode_d = SET_M;
        SET_M:   mode_d = SET_S;
        SET_S:   mode_d = RUN;
        default: mode_d = RUN;
      endcase
    end else begin
      mode_d = mode_q;
    end
  end

  // Prescaler only counts while staying in RUN, so a new RUN period starts from zero.
  always_comb begin
    run_s  = (mode_q == RUN) && (mode_d == RUN);
    tick_s = run_s && (presc_q == PRESC_LAST);
    if (!run_s) begin
      presc_d = '0;
    end else if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1'b1);
    end
  end

  // Time update: cascaded carry on tick, or single-field edit in a set mode.
  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (tick_s) begin
      sec_d = inc6(sec_q, MS_LAST);
      if (sec_q == MS_LAST) begin
        min_d = inc6(min_q, MS_LAST);
        if (min_q == MS_LAST) begin
          hr_d = inc5(hr_q, HR_LAST);
        end else begin
          hr_d = hr_q;
        end
      end else begin
        min_d = min_q;
      end
    end else begin
      case (mode_q)
        SET_H: begin
          if (edit_inc_s) begin
            hr_d = inc5(hr_q, HR_LAST);
          end else if (edit_dec_s) begin
            hr_d = dec5(hr_q, HR_LAST);
          end else begin
            hr_d = hr_q;
          end
        end
        SET_M: begin
          if (edit_inc_s) begin
            min_d = inc6(min_q, MS_LAST);
          end else if (edit_dec_s) begin
            min_d = dec6(min_q, MS_LAST);
          end else begin
            min_d = min_q;
          end
        end
        SET_S: begin
          if (edit_inc_s) begin
            sec_d = inc6(sec_q, MS_LAST);
          end else if (edit_dec_s) begin
            sec_d = dec6(sec_q, MS_LAST);
          end else begin
            sec_d = sec_q;
          end
        end
        default: begin
          sec_d = sec_q;
        end
      endcase
    end
  end

  // Blink divider restarts visible whenever a new field is selected for editing.
  always_comb begin
    entering_set_s = cfg_ev_s && (mode_d != RUN);
    if (entering_set_s) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1'b1);
      phase_d     = phase_q;
    end
    if (mode_d == RUN) begin
      blink_d = 1'b1;
    end else begin
      blink_d = phase_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_100MHz_i) begin
    if (reset_i) begin
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      cfg_q       <= 1'b0;
      mode_q      <= RUN;
      presc_q     <= '0;
      sec_q       <= 6'd0;
      min_q       <= 6'd0;
      hr_q        <= 5'd0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      blink_q     <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      inc_q       <= increment_i;
      dec_q       <= decrement_i;
      cfg_q       <= config_i;
      mode_q      <= mode_d;
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      blink_q     <= blink_d;
      tick_q      <= tick_s;
    end
  end

  assign seconds_o = sec_q;
  assign minutes_o = min_q;
  assign hours_o   = hr_q;
  assign mode_o    = mode_q;
  assign blink_o   = blink_q;
  assign tick_o    = tick_q;

endmodule

// File: tb/tb_rtc_set_core.sv
// Directed bench for rtc_set_core: 10-cycle tick, 4-cycle blink half-period,
// one 24-hour and one 12-hour instance sharing the same stimulus.
module tb_rtc_set_core;

  logic       clk;
  logic       reset_i, increment_i, decrement_i, config_i;
  logic [5:0] s24, m24, s12, m12;
  logic [4:0] h24, h12;
  logic [1:0] mode24, mode12;
  logic       blink24, blink12, tick24, tick12;

  int n_cmp = 0;
  int n_err = 0;

  rtc_set_core #(.CLK_FREQ_HZ(10), .TICK_HZ(1), .BLINK_DIV(4), .HOURS_MAX(24)) dut24 (
    .clk_100MHz_i(clk), .reset_i(reset_i), .increment_i(increment_i),
    .decrement_i(decrement_i), .config_i(config_i),
    .seconds_o(s24), .minutes_o(m24), .hours_o(h24),
    .mode_o(mode24), .blink_o(blink24), .tick_o(tick24)
  );

  rtc_set_core #(.CLK_FREQ_HZ(10), .TICK_HZ(1), .BLINK_DIV(4), .HOURS_MAX(12)) dut12 (
    .clk_100MHz_i(clk), .reset_i(reset_i), .increment_i(increment_i),
    .decrement_i(decrement_i), .config_i(config_i),
    .seconds_o(s12), .minutes_o(m12), .hours_o(h12),
    .mode_o(mode12), .blink_o(blink12), .tick_o(tick12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic pi, input logic pd, input logic pc);
    increment_i = pi; decrement_i = pd; config_i = pc;
    step(1);
    increment_i = 1'b0; decrement_i = 1'b0; config_i = 1'b0;
    step(1);
  endtask

  task automatic do_reset();
    reset_i = 1'b1; increment_i = 1'b0; decrement_i = 1'b0; config_i = 1'b0;
    step(2);
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; increment_i = 1'b0; decrement_i = 1'b0; config_i = 1'b1;
    step(2);
    n_cmp++;
    if ({h24, m24, s24} !== {5'd0, 6'd0, 6'd0}) begin
      n_err++; $display("FAIL reset_time: got %0d:%0d:%0d expected 0:0:0", h24, m24, s24);
    end
    n_cmp++;
    if ({mode24, blink24, tick24} !== {2'd0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL reset_ctrl: got mode=%0d blink=%0d tick=%0d expected 0 1 0", mode24, blink24, tick24);
    end
    reset_i = 1'b0;
    step(1);
    n_cmp++;
    if (mode24 !== 2'd1) begin
      n_err++; $display("FAIL reset_held_cfg: got mode=%0d expected 1", mode24);
    end
    config_i = 1'b0;
    step(1);
  endtask

  task automatic test_run();
    int ticks;
    int first_at;
    int last_at;
    int bad_gap;
    ticks = 0; first_at = -1; last_at = 0; bad_gap = 0;
    do_reset();
    for (int i = 1; i <= 600; i++) begin
      step(1);
      if (tick24 === 1'b1) begin
        ticks++;
        if (first_at < 0) first_at = i;
        else if (i - last_at != 10) bad_gap++;
        last_at = i;
      end
    end
    n_cmp++;
    if (ticks !== 60) begin
      n_err++; $display("FAIL run_tick_count: got %0d expected 60", ticks);
    end
    n_cmp++;
    if (first_at !== 10 || bad_gap !== 0) begin
      n_err++; $display("FAIL run_tick_period: got first=%0d badgaps=%0d expected 10 0", first_at, bad_gap);
    end
    n_cmp++;
    if ({h24, m24, s24, mode24} !== {5'd0, 6'd1, 6'd0, 2'd0}) begin
      n_err++; $display("FAIL run_time: got %0d:%0d:%0d mode=%0d expected 0:1:0 mode=0", h24, m24, s24, mode24);
    end
  endtask

  task automatic test_rollover();
    do_reset();
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({h24, m24, s24, mode24} !== {5'd0, 6'd59, 6'd59, 2'd0}) begin
      n_err++; $display("FAIL preload_0_59_59: got %0d:%0d:%0d mode=%0d", h24, m24, s24, mode24);
    end
    step(8);
    n_cmp++;
    if (tick24 !== 1'b0 || s24 !== 6'd59) begin
      n_err++; $display("FAIL early_tick: got tick=%0d s=%0d expected 0 59", tick24, s24);
    end
    step(1);
    n_cmp++;
    if ({tick24, h24, m24, s24} !== {1'b1, 5'd1, 6'd0, 6'd0}) begin
      n_err++; $display("FAIL carry_hour: got tick=%0d %0d:%0d:%0d expected 1 1:0:0", tick24, h24, m24, s24);
    end

    do_reset();
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({h24, m24, s24, h12, m12, s12} !== {5'd23, 6'd59, 6'd59, 5'd11, 6'd59, 6'd59}) begin
      n_err++; $display("FAIL preload_max: got %0d:%0d:%0d / %0d:%0d:%0d expected 23:59:59 / 11:59:59", h24, m24, s24, h12, m12, s12);
    end
    step(9);
    n_cmp++;
    if ({tick24, h24, m24, s24} !== {1'b1, 5'd0, 6'd0, 6'd0}) begin
      n_err++; $display("FAIL wrap_day24: got tick=%0d %0d:%0d:%0d expected 1 0:0:0", tick24, h24, m24, s24);
    end
    n_cmp++;
    if ({tick12, h12, m12, s12, mode12, blink12} !== {1'b1, 5'd0, 6'd0, 6'd0, 2'd0, 1'b1}) begin
      n_err++; $display("FAIL wrap_day12: got tick=%0d %0d:%0d:%0d mode=%0d blink=%0d expected 1 0:0:0 0 1", tick12, h12, m12, s12, mode12, blink12);
    end
  endtask

  task automatic test_set_hours();
    do_reset();
    config_i = 1'b1;
    step(1);
    n_cmp++;
    if (mode24 !== 2'd1) begin
      n_err++; $display("FAIL cfg_latency: got mode=%0d expected 1", mode24);
    end
    config_i = 1'b0;
    step(1);
    pulse(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (h24 !== 5'd23) begin
      n_err++; $display("FAIL hour_dec_wrap: got %0d expected 23", h24);
    end
    repeat (3) pulse(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (h24 !== 5'd2) begin
      n_err++; $display("FAIL hour_inc3: got %0d expected 2", h24);
    end
    increment_i = 1'b1;
    step(50);
    increment_i = 1'b0;
    step(1);
    n_cmp++;
    if (h24 !== 5'd3) begin
      n_err++; $display("FAIL hold_inc_once: got %0d expected 3", h24);
    end
  endtask

  task automatic test_config_seq();
    int ticks;
    ticks = 0;
    do_reset();
    pulse(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (mode24 !== 2'd1) begin
      n_err++; $display("FAIL seq_mode1: got %0d expected 1", mode24);
    end
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (tick24 === 1'b1) ticks++;
    end
    n_cmp++;
    if (ticks !== 0 || s24 !== 6'd0) begin
      n_err++; $display("FAIL set_no_tick: got ticks=%0d s=%0d expected 0 0", ticks, s24);
    end
    pulse(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (mode24 !== 2'd2) begin
      n_err++; $display("FAIL seq_mode2: got %0d expected 2", mode24);
    end
    pulse(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (mode24 !== 2'd3) begin
      n_err++; $display("FAIL seq_mode3: got %0d expected 3", mode24);
    end
    pulse(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (mode24 !== 2'd0) begin
      n_err++; $display("FAIL seq_mode0: got %0d expected 0", mode24);
    end
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (tick24 === 1'b1) ticks++;
    end
    step(1);
    n_cmp++;
    if (ticks !== 0 || tick24 !== 1'b1 || s24 !== 6'd1) begin
      n_err++; $display("FAIL first_tick_10: got early=%0d tick=%0d s=%0d expected 0 1 1", ticks, tick24, s24);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (m24 !== 6'd1) begin
      n_err++; $display("FAIL inc_dec_cancel: got min=%0d expected 1", m24);
    end
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (m24 !== 6'd59) begin
      n_err++; $display("FAIL min_dec_wrap: got %0d expected 59", m24);
    end
    pulse(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if ({mode24, m24, s24} !== {2'd3, 6'd59, 6'd0}) begin
      n_err++; $display("FAIL cfg_wins: got mode=%0d m=%0d s=%0d expected 3 59 0", mode24, m24, s24);
    end
    pulse(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (s24 !== 6'd59) begin
      n_err++; $display("FAIL sec_dec_wrap: got %0d expected 59", s24);
    end
    pulse(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({s24, m24, h24} !== {6'd0, 6'd59, 5'd0}) begin
      n_err++; $display("FAIL sec_inc_nocarry: got s=%0d m=%0d h=%0d expected 0 59 0", s24, m24, h24);
    end
  endtask

  task automatic test_blink_reset();
    logic exp_b;
    do_reset();
    step(3);
    n_cmp++;
    if (blink24 !== 1'b1) begin
      n_err++; $display("FAIL blink_run: got %0d expected 1", blink24);
    end
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    config_i = 1'b1;
    step(1);
    config_i = 1'b0;
    for (int i = 0; i < 14; i++) begin
      exp_b = ((i / 4) % 2 == 0) ? 1'b1 : 1'b0;
      n_cmp++;
      if (blink24 !== exp_b || mode24 !== 2'd3) begin
        n_err++; $display("FAIL blink_phase[%0d]: got blink=%0d mode=%0d expected %0d 3", i, blink24, mode24, exp_b);
      end
      step(1);
    end
    reset_i = 1'b1;
    step(1);
    reset_i = 1'b0;
    n_cmp++;
    if ({mode24, blink24, h24, m24, s24} !== {2'd0, 1'b1, 5'd0, 6'd0, 6'd0}) begin
      n_err++; $display("FAIL reset_mid_edit: got mode=%0d blink=%0d %0d:%0d:%0d expected 0 1 0:0:0", mode24, blink24, h24, m24, s24);
    end
  endtask

  initial begin
    reset_i = 1'b1; increment_i = 1'b0; decrement_i = 1'b0; config_i = 1'b0;
    test_reset();
    test_run();
    test_rollover();
    test_set_hours();
    test_config_seq();
    test_simultaneous();
    test_blink_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
